// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the elastic pipeline controller.
// Stage masks are carried in a fixed-width vector wide enough for any supported depth.
package pipe_ctrl_pkg;

    localparam int unsigned MAX_STAGES = 32;

    typedef logic [MAX_STAGES-1:0] stage_mask_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int unsigned popcount(input stage_mask_t m);
        int unsigned c;
        c = 0;
        for (int i = 0; i < MAX_STAGES; i++) begin
            c = c + 32'(m[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/pipe_ctrl_stage_reg.sv
// One pipeline slot: a reset valid bit plus an unreset payload register.
// Kill clears the slot; bubble makes an enabled load arrive empty.
module pipe_stage_reg #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_en,
    input  logic                  i_kill,
    input  logic                  i_bubble,
    input  logic                  i_d_valid,
    input  logic [DATA_WIDTH-1:0] i_d_data,
    output logic                  o_valid,
    output logic                  o_valid_nxt,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  w_valid_nxt;

    always_comb begin
        w_valid_nxt = r_valid;
        if (i_kill) begin
            w_valid_nxt = 1'b0;
        end else if (i_en) begin
            w_valid_nxt = i_d_valid && !i_bubble;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_valid_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (i_en) begin
            r_data <= i_d_data;
        end
    end

    assign o_valid     = r_valid;
    assign o_valid_nxt = w_valid_nxt;
    assign o_data      = r_data;

endmodule

// File: rtl/pipe_ctrl.sv
// N-stage elastic pipeline: ready/valid enable chain, hazard hold with bubble
// insertion, partial flush, registered occupancy and saturating retire/bubble counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned STAGES     = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 32,
    localparam int unsigned IDX_W     = clog2(STAGES),
    localparam int unsigned OCC_W     = clog2(STAGES + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_WIDTH-1:0]        in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    input  logic                         hold,
    input  logic [IDX_W-1:0]             hold_stage,
    input  logic                         flush,
    input  logic [IDX_W-1:0]             flush_stage,
    output logic [STAGES-1:0]            stage_valid,
    output logic [STAGES*DATA_WIDTH-1:0] stage_data,
    output logic [OCC_W-1:0]             occupancy,
    output logic [CNT_WIDTH-1:0]         retired_cnt,
    output logic [CNT_WIDTH-1:0]         bubble_cnt
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(STAGES - 1);

    logic [IDX_W-1:0]      w_hold_idx;
    logic [IDX_W-1:0]      w_flush_idx;
    logic [STAGES-1:0]     w_hold_mask;
    logic [STAGES-1:0]     w_flush_mask;
    logic [STAGES-1:0]     w_bubble;
    logic [STAGES-1:0]     w_en;
    logic [STAGES-1:0]     w_valid;
    logic [STAGES-1:0]     w_valid_nxt;
    logic [STAGES-1:0]     w_d_valid;
    logic [DATA_WIDTH-1:0] w_d_data [STAGES];
    logic [DATA_WIDTH-1:0] w_data   [STAGES];
    logic                  w_carry;
    logic                  w_retire;
    logic                  w_bubble_inc;

    logic [OCC_W-1:0]      r_occ;
    logic [CNT_WIDTH-1:0]  r_retired;
    logic [CNT_WIDTH-1:0]  r_bubbles;

    assign w_hold_idx  = ({1'b0, hold_stage} >= (IDX_W + 1)'(STAGES)) ? LAST : hold_stage;
    assign w_flush_idx = ({1'b0, flush_stage} >= (IDX_W + 1)'(STAGES)) ? LAST : flush_stage;

    // The first un-held stage past the hold boundary receives the bubble.
    always_comb begin
        w_hold_mask  = '0;
        w_flush_mask = '0;
        w_bubble     = '0;
        for (int i = 0; i < int'(STAGES); i++) begin
            w_hold_mask[i]  = hold && (IDX_W'(i) <= w_hold_idx);
            w_flush_mask[i] = flush && (IDX_W'(i) <= w_flush_idx);
        end
        for (int i = 1; i < int'(STAGES); i++) begin
            w_bubble[i] = w_hold_mask[i-1] && !w_hold_mask[i];
        end
    end

    always_comb begin
        w_en    = '0;
        w_carry = out_ready;
        for (int i = int'(STAGES) - 1; i >= 0; i--) begin
            w_en[i] = !w_hold_mask[i] && (!w_valid[i] || w_carry);
            w_carry = w_en[i];
        end
    end

    for (genvar g = 0; g < int'(STAGES); g++) begin : g_stage
        if (g == 0) begin : g_head
            assign w_d_valid[g] = in_valid;
            assign w_d_data[g]  = in_data;
        end else begin : g_body
            assign w_d_valid[g] = w_valid[g-1];
            assign w_d_data[g]  = w_data[g-1];
        end

        pipe_stage_reg #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_stage_reg (
            .clk         (clk),
            .rst         (rst),
            .i_en        (w_en[g]),
            .i_kill      (w_flush_mask[g]),
            .i_bubble    (w_bubble[g]),
            .i_d_valid   (w_d_valid[g]),
            .i_d_data    (w_d_data[g]),
            .o_valid     (w_valid[g]),
            .o_valid_nxt (w_valid_nxt[g]),
            .o_data      (w_data[g])
        );

        assign stage_data[g*DATA_WIDTH +: DATA_WIDTH] = w_data[g];
    end

    assign w_retire     = w_valid[STAGES-1] && out_ready;
    assign w_bubble_inc = |(w_bubble & w_en & ~w_flush_mask);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_occ     <= '0;
            r_retired <= '0;
            r_bubbles <= '0;
        end else begin
            r_occ <= OCC_W'(popcount(stage_mask_t'(w_valid_nxt)));
            if (w_retire && (r_retired != '1)) begin
                r_retired <= r_retired + CNT_WIDTH'(1);
            end
            if (w_bubble_inc && (r_bubbles != '1)) begin
                r_bubbles <= r_bubbles + CNT_WIDTH'(1);
            end
        end
    end

    assign in_ready    = w_en[0] && !flush;
    assign out_valid   = w_valid[STAGES-1];
    assign out_data    = w_data[STAGES-1];
    assign stage_valid = w_valid;
    assign occupancy   = r_occ;
    assign retired_cnt = r_retired;
    assign bubble_cnt  = r_bubbles;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (5 stages): vector table for streaming, stall,
// hold and flush, then hand sequences for flush+hold, clamping and async reset.
module tb_pipe_ctrl;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic         hold;
    logic [2:0]   hold_stage;
    logic         flush;
    logic [2:0]   flush_stage;
    logic [4:0]   stage_valid;
    logic [159:0] stage_data;
    logic [2:0]   occupancy;
    logic [31:0]  retired_cnt;
    logic [31:0]  bubble_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_ctrl #(
        .STAGES     (5),
        .DATA_WIDTH (32),
        .CNT_WIDTH  (32)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .hold        (hold),
        .hold_stage  (hold_stage),
        .flush       (flush),
        .flush_stage (flush_stage),
        .stage_valid (stage_valid),
        .stage_data  (stage_data),
        .occupancy   (occupancy),
        .retired_cnt (retired_cnt),
        .bubble_cnt  (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic        iv;
        logic [31:0] id;
        logic        ordy;
        logic        hd;
        logic [2:0]  hs;
        logic        fl;
        logic [2:0]  fs;
        logic        e_rdy;
        logic [4:0]  e_sv;
        logic [31:0] e_out;
        logic [2:0]  e_occ;
        logic [31:0] e_ret;
        logic [31:0] e_bub;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mk(input logic iv, input logic [31:0] id, input logic ordy,
                                input logic hd, input logic [2:0] hs, input logic fl,
                                input logic [2:0] fs, input logic e_rdy, input logic [4:0] e_sv,
                                input logic [31:0] e_out, input logic [2:0] e_occ,
                                input logic [31:0] e_ret, input logic [31:0] e_bub);
        vec_t v;
        v.iv = iv; v.id = id; v.ordy = ordy; v.hd = hd; v.hs = hs; v.fl = fl; v.fs = fs;
        v.e_rdy = e_rdy; v.e_sv = e_sv; v.e_out = e_out; v.e_occ = e_occ;
        v.e_ret = e_ret; v.e_bub = e_bub;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic iv, input logic [31:0] id, input logic ordy,
                          input logic hd, input logic [2:0] hs, input logic fl,
                          input logic [2:0] fs);
        in_valid = iv; in_data = id; out_ready = ordy;
        hold = hd; hold_stage = hs; flush = fl; flush_stage = fs;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] sd(input int i);
        return stage_data[i*32 +: 32];
    endfunction

    initial begin
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("reset_stage_valid", 32'(stage_valid), 0);
        chk("reset_occupancy", 32'(occupancy), 0);
        chk("reset_retired", retired_cnt, 0);
        chk("reset_bubble", bubble_cnt, 0);
        #10;
        rst = 1'b1;
        #1;
        chk("reset_in_ready", 32'(in_ready), 1);
        tick();

        // Streaming: out_data=1 after 5 edges
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 1, 5'b00001, 0, 1, 0, 0));
        vecs.push_back(mk(1, 2, 1, 0, 0, 0, 0, 1, 5'b00011, 0, 2, 0, 0));
        vecs.push_back(mk(1, 3, 1, 0, 0, 0, 0, 1, 5'b00111, 0, 3, 0, 0));
        vecs.push_back(mk(1, 4, 1, 0, 0, 0, 0, 1, 5'b01111, 0, 4, 0, 0));
        vecs.push_back(mk(1, 5, 1, 0, 0, 0, 0, 1, 5'b11111, 1, 5, 0, 0));
        vecs.push_back(mk(1, 6, 1, 0, 0, 0, 0, 1, 5'b11111, 2, 5, 1, 0));
        vecs.push_back(mk(1, 7, 1, 0, 0, 0, 0, 1, 5'b11111, 3, 5, 2, 0));
        vecs.push_back(mk(1, 8, 1, 0, 0, 0, 0, 1, 5'b11111, 4, 5, 3, 0));
        // Downstream stall for 3 cycles, then release
        vecs.push_back(mk(1, 9, 0, 0, 0, 0, 0, 0, 5'b11111, 4, 5, 3, 0));
        vecs.push_back(mk(1, 9, 0, 0, 0, 0, 0, 0, 5'b11111, 4, 5, 3, 0));
        vecs.push_back(mk(1, 9, 0, 0, 0, 0, 0, 0, 5'b11111, 4, 5, 3, 0));
        vecs.push_back(mk(1, 9, 1, 0, 0, 0, 0, 1, 5'b11111, 5, 5, 4, 0));
        vecs.push_back(mk(1, 10, 1, 0, 0, 0, 0, 1, 5'b11111, 6, 5, 5, 0));
        vecs.push_back(mk(1, 11, 1, 0, 0, 0, 0, 1, 5'b11111, 7, 5, 6, 0));
        vecs.push_back(mk(1, 12, 1, 0, 0, 0, 0, 1, 5'b11111, 8, 5, 7, 0));
        vecs.push_back(mk(1, 13, 1, 0, 0, 0, 0, 1, 5'b11111, 9, 5, 8, 0));
        // Hold stages 0..1 for 2 cycles: bubbles enter at stage 2
        vecs.push_back(mk(1, 14, 1, 1, 1, 0, 0, 0, 5'b11011, 10, 4, 9, 1));
        vecs.push_back(mk(1, 14, 1, 1, 1, 0, 0, 0, 5'b10011, 11, 3, 10, 2));
        vecs.push_back(mk(1, 14, 1, 0, 0, 0, 0, 1, 5'b00111, 0, 3, 11, 2));
        vecs.push_back(mk(1, 15, 1, 0, 0, 0, 0, 1, 5'b01111, 0, 4, 11, 2));
        vecs.push_back(mk(1, 16, 1, 0, 0, 0, 0, 1, 5'b11111, 12, 5, 11, 2));
        vecs.push_back(mk(1, 17, 1, 0, 0, 0, 0, 1, 5'b11111, 13, 5, 12, 2));
        // Flush stages 0..2 on a full pipe: two survivors drain
        vecs.push_back(mk(1, 18, 1, 0, 0, 1, 2, 0, 5'b11000, 14, 2, 13, 2));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 5'b10000, 15, 1, 14, 2));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 5'b00000, 0, 0, 15, 2));

        for (int i = 0; i < vecs.size(); i++) begin
            set_in(vecs[i].iv, vecs[i].id, vecs[i].ordy, vecs[i].hd, vecs[i].hs,
                   vecs[i].fl, vecs[i].fs);
            #1;
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_rdy));
            tick();
            chk($sformatf("v%0d_stage_valid", i), 32'(stage_valid), 32'(vecs[i].e_sv));
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_sv[4]));
            if (vecs[i].e_sv[4]) begin
                chk($sformatf("v%0d_out_data", i), out_data, vecs[i].e_out);
            end
            chk($sformatf("v%0d_occupancy", i), 32'(occupancy), 32'(vecs[i].e_occ));
            chk($sformatf("v%0d_retired", i), retired_cnt, vecs[i].e_ret);
            chk($sformatf("v%0d_bubble", i), bubble_cnt, vecs[i].e_bub);
        end

        // Fill with 20..24 while output is blocked
        for (int k = 0; k < 5; k++) begin
            set_in(1, 32'(20 + k), 0, 0, 0, 0, 0);
            #1;
            chk("fill1_in_ready", 32'(in_ready), 1);
            tick();
        end
        chk("fill1_stage_valid", 32'(stage_valid), 32'h1f);
        chk("fill1_s0", sd(0), 24);
        chk("fill1_s4", sd(4), 20);

        // Flush 0..1 together with hold 0..3
        set_in(0, 0, 1, 1, 3, 1, 1);
        #1;
        chk("fh_in_ready", 32'(in_ready), 0);
        tick();
        chk("fh_stage_valid", 32'(stage_valid), 32'b01100);
        chk("fh_s2", sd(2), 22);
        chk("fh_s3", sd(3), 21);
        chk("fh_bubble", bubble_cnt, 3);
        chk("fh_retired", retired_cnt, 16);
        chk("fh_occupancy", 32'(occupancy), 2);
        set_in(0, 0, 1, 0, 0, 0, 0);
        tick();
        chk("fh_drain1_sv", 32'(stage_valid), 32'b11000);
        chk("fh_drain1_out", out_data, 21);
        tick();
        chk("fh_drain2_sv", 32'(stage_valid), 32'b10000);
        chk("fh_drain2_out", out_data, 22);
        chk("fh_drain2_ret", retired_cnt, 17);
        tick();
        chk("fh_drain3_sv", 32'(stage_valid), 0);
        chk("fh_drain3_ret", retired_cnt, 18);

        // Clamped indices: hold_stage=7 freezes all, flush_stage=6 clears all
        for (int k = 0; k < 5; k++) begin
            set_in(1, 32'(50 + k), 0, 0, 0, 0, 0);
            tick();
        end
        set_in(1, 55, 0, 1, 7, 0, 0);
        #1;
        chk("clamp_hold_in_ready", 32'(in_ready), 0);
        tick();
        chk("clamp_hold_sv", 32'(stage_valid), 32'h1f);
        chk("clamp_hold_s0", sd(0), 54);
        chk("clamp_hold_bubble", bubble_cnt, 3);
        set_in(0, 0, 1, 0, 0, 1, 6);
        #1;
        chk("clamp_flush_in_ready", 32'(in_ready), 0);
        tick();
        chk("clamp_flush_sv", 32'(stage_valid), 0);
        chk("clamp_flush_retired", retired_cnt, 19);
        chk("clamp_flush_occ", 32'(occupancy), 0);

        // Async reset mid-stream, then clean restart
        for (int k = 0; k < 6; k++) begin
            set_in(1, 32'(30 + k), 1, 0, 0, 0, 0);
            tick();
        end
        chk("pre_rst_out", out_data, 31);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_stage_valid", 32'(stage_valid), 0);
        chk("arst_occupancy", 32'(occupancy), 0);
        chk("arst_retired", retired_cnt, 0);
        chk("arst_bubble", bubble_cnt, 0);
        tick();
        chk("arst_held_sv", 32'(stage_valid), 0);
        #3;
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            set_in(1, 32'(40 + k), 1, 0, 0, 0, 0);
            #1;
            chk("restart_in_ready", 32'(in_ready), 1);
            tick();
        end
        chk("restart_out_valid", 32'(out_valid), 1);
        chk("restart_out_data", out_data, 40);
        chk("restart_retired", retired_cnt, 0);
        set_in(0, 0, 1, 0, 0, 0, 0);
        tick();
        chk("restart_out_data2", out_data, 41);
        chk("restart_retired2", retired_cnt, 1);
        chk("restart_occ", 32'(occupancy), 4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
